dp_ram_be: RTL and testbench

Parametrised simple-dual-port RAM: one write port and one read port, both on the same clock. Successor to the single-port async-read RAM. Adds per-lane byte enables, a registered read with valid flag, and a hardware clear-on-reset sequencer so contents are defined after reset. Used as program/data memory and scratch buffer behind the datapath.

---
 rtl/dp_ram_be.sv | 152 +++++++++++++++
 tb/tb_dp_ram_be.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// dp_ram_be: simple-dual-port RAM (one write port, one read port, one clock)
// with per-lane byte enables, a registered read with a valid pulse, and a
// clear sequencer that fills every word with INIT_VALUE after reset.
//
// Optional build macro: WR_FIRST_BYPASS_EN
//   defined   -> a same-address read/write on one edge returns write-first
//                data (written lanes from w_data, other lanes from memory)
//   undefined -> read-first: the read returns the word as it was before the
//                write, matching a block RAM without bypass logic
//   The memory array is updated identically in both builds.
//
// Ports:
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous active-high reset; restarts the clear sequencer
//   init_busy  high while the clear sequencer runs (user ports are ignored)
//   wr_en      write request
//   wr_addr    write address
//   wr_be      lane enables, bit i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
//   w_data     write data
//   rd_en      read request
//   rd_addr    read address
//   r_data     registered read data, holds between reads
//   r_valid    one-cycle pulse marking r_data as fresh
module dp_ram_be #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    BYTE_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                init_busy,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wr_be,
    input  logic [DATA_WIDTH-1:0]               w_data,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               r_data,
    output logic                                r_valid
);

    localparam int                    NB        = DATA_WIDTH / BYTE_WIDTH;
    localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   rd_data_p1;
    logic                    vld_p1;

`ifdef WR_FIRST_BYPASS_EN
    // Lane-wise merge: enabled lanes take new data, the rest keep old data.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return res;
    endfunction
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: leave INIT on the edge that clears the last address
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (clr_cnt == LAST_ADDR) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        init_busy = (state == S_INIT);
        ready     = (state == S_READY);
    end

    // Clear address counter; it wraps to 0 on leaving INIT and then idles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == S_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Memory array has no reset; the sequencer owns the write port in INIT
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[clr_cnt] <= INIT_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word seen at the edge; the array read returns pre-write contents
    always_comb begin
        rd_word = mem[rd_addr];
`ifdef WR_FIRST_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word = lane_merge(mem[rd_addr], w_data, wr_be);
        end
`endif
    end

    // ---- stage p1: registered read data and valid ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            vld_p1 <= rd_en && ready;
            if (rd_en && ready) begin
                rd_data_p1 <= rd_word;
            end
        end
    end

    assign r_data  = rd_data_p1;
    assign r_valid = vld_p1;

endmodule

// File: tb/tb_dp_ram_be.sv
// Directed bench for dp_ram_be: an 8-bit instance (ADDR_WIDTH=4,
// INIT_VALUE=8'hA5) covers clear, ignore-during-init, collision, streaming
// and reset; a 32-bit instance covers byte enables and partial collisions.
`timescale 1ns/1ps
module tb_dp_ram_be;

    localparam int          AW     = 4;
    localparam int          DEPTH  = 16;
    localparam logic [7:0]  INIT8  = 8'hA5;
    localparam logic [31:0] INIT32 = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic          rst8 = 1'b1;
    logic          busy8;
    logic          we8 = 1'b0;
    logic [AW-1:0] wa8 = '0;
    logic [0:0]    be8 = 1'b1;
    logic [7:0]    wd8 = '0;
    logic          re8 = 1'b0;
    logic [AW-1:0] ra8 = '0;
    logic [7:0]    rd8;
    logic          rv8;

    // 32-bit instance
    logic          rst32 = 1'b1;
    logic          busy32;
    logic          we32 = 1'b0;
    logic [AW-1:0] wa32 = '0;
    logic [3:0]    be32 = '0;
    logic [31:0]   wd32 = '0;
    logic          re32 = 1'b0;
    logic [AW-1:0] ra32 = '0;
    logic [31:0]   rd32;
    logic          rv32;

    dp_ram_be #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .INIT_VALUE(INIT8)) u_dut8 (
        .clk(clk), .rst(rst8), .init_busy(busy8),
        .wr_en(we8), .wr_addr(wa8), .wr_be(be8), .w_data(wd8),
        .rd_en(re8), .rd_addr(ra8), .r_data(rd8), .r_valid(rv8)
    );

    dp_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .INIT_VALUE(INIT32)) u_dut32 (
        .clk(clk), .rst(rst32), .init_busy(busy32),
        .wr_en(we32), .wr_addr(wa32), .wr_be(be32), .w_data(wd32),
        .rd_en(re32), .rd_addr(ra32), .r_data(rd32), .r_valid(rv32)
    );

    int checks = 0;
    int errors = 0;

    // Reference models and scoreboards
    logic [7:0]  m8  [DEPTH];
    logic [31:0] m32 [DEPTH];
    int          cnt8  = 0;
    int          cnt32 = 0;
    logic [7:0]  last8  = '0;
    logic [31:0] last32 = '0;
    logic [7:0]  q8  [$];
    logic [31:0] q32 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge32(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic cyc8(input logic we, input logic [AW-1:0] wa, input logic [7:0] wd,
                        input logic re, input logic [AW-1:0] ra, input string tag);
        logic       rdy;
        logic [7:0] e;
        rdy = (cnt8 == DEPTH);
        we8 = we; wa8 = wa; wd8 = wd; be8 = 1'b1; re8 = re; ra8 = ra;
        if (rdy && re) begin
            e = m8[ra];
`ifdef WR_FIRST_BYPASS_EN
            if (we && (wa == ra)) e = wd;
`endif
            q8.push_back(e);
        end
        if (rdy && we) m8[wa] = wd;
        @(posedge clk); #1;
        if (!rdy) begin
            m8[cnt8[AW-1:0]] = INIT8;
            cnt8++;
        end
        check($sformatf("%s.busy", tag), 32'(busy8), 32'(cnt8 != DEPTH));
        if (q8.size() > 0) begin
            e = q8.pop_front();
            check($sformatf("%s.valid", tag), 32'(rv8), 32'd1);
            check($sformatf("%s.data", tag), 32'(rd8), 32'(e));
            last8 = e;
        end else begin
            check($sformatf("%s.valid", tag), 32'(rv8), 32'd0);
            check($sformatf("%s.hold", tag), 32'(rd8), 32'(last8));
        end
    endtask

    task automatic cyc32(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic [3:0] be, input logic re, input logic [AW-1:0] ra,
                         input string tag);
        logic        rdy;
        logic [31:0] e;
        rdy = (cnt32 == DEPTH);
        we32 = we; wa32 = wa; wd32 = wd; be32 = be; re32 = re; ra32 = ra;
        if (rdy && re) begin
            e = m32[ra];
`ifdef WR_FIRST_BYPASS_EN
            if (we && (wa == ra)) e = merge32(m32[ra], wd, be);
`endif
            q32.push_back(e);
        end
        if (rdy && we) m32[wa] = merge32(m32[wa], wd, be);
        @(posedge clk); #1;
        if (!rdy) begin
            m32[cnt32[AW-1:0]] = INIT32;
            cnt32++;
        end
        check($sformatf("%s.busy32", tag), 32'(busy32), 32'(cnt32 != DEPTH));
        if (q32.size() > 0) begin
            e = q32.pop_front();
            check($sformatf("%s.valid32", tag), 32'(rv32), 32'd1);
            check($sformatf("%s.data32", tag), rd32, e);
            last32 = e;
        end else begin
            check($sformatf("%s.valid32", tag), 32'(rv32), 32'd0);
            check($sformatf("%s.hold32", tag), rd32, last32);
        end
    endtask

    // Asserts rst mid-cycle, checks the asynchronous clear, releases after two edges
    task automatic reset8(input string tag);
        #2;
        we8 = 1'b0; re8 = 1'b0;
        rst8 = 1'b1;
        #1;
        check($sformatf("%s.rst_valid", tag), 32'(rv8), 32'd0);
        check($sformatf("%s.rst_data", tag), 32'(rd8), 32'd0);
        check($sformatf("%s.rst_busy", tag), 32'(busy8), 32'd1);
        q8.delete();
        last8 = '0;
        cnt8  = 0;
        @(posedge clk); @(posedge clk); #1;
        rst8 = 1'b0;
    endtask

    task automatic reset32(input string tag);
        #2;
        we32 = 1'b0; re32 = 1'b0;
        rst32 = 1'b1;
        #1;
        check($sformatf("%s.rst_valid32", tag), 32'(rv32), 32'd0);
        check($sformatf("%s.rst_data32", tag), rd32, 32'd0);
        q32.delete();
        last32 = '0;
        cnt32  = 0;
        @(posedge clk); @(posedge clk); #1;
        rst32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on clear while user ports request a write of 8'h5A and a read
        reset8("por");
        for (int i = 0; i < DEPTH; i++) cyc8(1'b1, 4'd0, 8'h5A, 1'b1, 4'd0, "init_ignore");
        for (int i = 0; i < DEPTH; i++) cyc8(1'b0, 4'd0, 8'h00, 1'b1, AW'(i), "clr_rd");
        cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "clr_idle");

        // Same-address collision, then independent read/write
        cyc8(1'b1, 4'd7, 8'h10, 1'b0, 4'd0, "wr7");
        cyc8(1'b1, 4'd7, 8'h77, 1'b1, 4'd7, "coll");
        cyc8(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, "coll_after");
        cyc8(1'b1, 4'd9, 8'h3C, 1'b1, 4'd7, "indep");
        cyc8(1'b0, 4'd0, 8'h00, 1'b1, 4'd9, "indep_rd");

        // Streaming read of addresses 0..3
        for (int i = 0; i < 4; i++) cyc8(1'b1, AW'(i), 8'hC0 + 8'(i), 1'b0, 4'd0, "stream_wr");
        for (int i = 0; i < 4; i++) cyc8(1'b0, 4'd0, 8'h00, 1'b1, AW'(i), "stream_rd");
        cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "stream_end");
        cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "stream_hold");

        // Reset while READY (r_data non-zero), then again at init count 5
        cyc8(1'b1, 4'd2, 8'hFF, 1'b0, 4'd0, "wr2");
        cyc8(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, "rd2");
        reset8("mid_ready");
        for (int i = 0; i < 5; i++) cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "part_init");
        reset8("mid_init");
        for (int i = 0; i < DEPTH; i++) cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "reinit");
        cyc8(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, "rd2_clr");
        cyc8(1'b0, 4'd0, 8'h00, 1'b1, 4'd7, "rd7_clr");
        cyc8(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, "done8");

        // 32-bit byte-enable checks
        reset32("por32");
        for (int i = 0; i < DEPTH; i++) cyc32(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, "init32");
        cyc32(1'b1, 4'd3, 32'h1122_3344, 4'hF,    1'b0, 4'd0, "be_full");
        cyc32(1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 1'b0, 4'd0, "be_part");
        cyc32(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd3, "be_rd");
        cyc32(1'b1, 4'd3, 32'hFFFF_FFFF, 4'b1000, 1'b1, 4'd3, "be_coll");
        cyc32(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd3, "be_coll_after");
        cyc32(1'b1, 4'd3, 32'h0,         4'h0,    1'b0, 4'd0, "be_zero");
        cyc32(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd3, "be_zero_rd");
        cyc32(1'b0, 4'd0, 32'h0,         4'h0,    1'b1, 4'd5, "rd5_init");
        cyc32(1'b0, 4'd0, 32'h0,         4'h0,    1'b0, 4'd0, "done32");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
